dm_access_unit: RTL and testbench

//  CPU-side initiator for the data-memory port: async-read, sync-write, word-wide only.

---
 rtl/dm_access_unit.sv | 159 +++++++++++++++
 tb/tb_dm_access_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Data-memory access unit: single outstanding load/store from the core MEM stage.
// Word-wide async-read / sync-write memory; sub-word stores use read-modify-write.
module dm_access_unit #(
    parameter int unsigned WORD_IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMerge,
        StWrite,
        StDone
    } state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [15:0] wdata_q;

    logic        bad_access;
    logic [31:0] word_addr;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign word_addr = {{(32 - WORD_IDX_W - 2){1'b0}}, addr[WORD_IDX_W+1:2], 2'b00};

    // Decode misaligned addresses and width codes that are illegal for the direction.
    always_comb begin
        bad_access = 1'b0;
        unique case (funct3)
            3'd0, 3'd4: bad_access = we && funct3[2];
            3'd1, 3'd5: bad_access = addr[0] || (we && funct3[2]);
            3'd2:       bad_access = addr[1:0] != 2'b00;
            default:    bad_access = 1'b1;
        endcase
    end

    // Lane select and sign/zero extension of the read word for loads.
    always_comb begin
        byte_sel = 8'h00;
        unique case (off_q)
            2'd0: byte_sel = dm_dout[7:0];
            2'd1: byte_sel = dm_dout[15:8];
            2'd2: byte_sel = dm_dout[23:16];
            2'd3: byte_sel = dm_dout[31:24];
        endcase
        half_sel = off_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (funct3_q)
            3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_ext = {24'h000000, byte_sel};
            3'd5:    load_ext = {16'h0000, half_sel};
            default: load_ext = dm_dout;
        endcase
    end

    // Read-modify-write merge: overwrite the addressed byte/half lane with store data.
    always_comb begin
        merged = dm_dout;
        if (funct3_q[1:0] == 2'd0) begin
            unique case (off_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Control FSM with all outputs registered; reset drops dm_we immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            off_q      <= 2'd0;
            funct3_q   <= 3'd0;
            wdata_q    <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            rdata      <= 32'h0;
            dm_addr    <= 32'h0;
            dm_we      <= 1'b0;
            dm_din     <= 32'h0;
        end else begin
            done  <= 1'b0;
            dm_we <= 1'b0;
            case (state)
                StIdle: begin
                    if (req) begin
                        busy     <= 1'b1;
                        off_q    <= addr[1:0];
                        funct3_q <= funct3;
                        wdata_q  <= wdata[15:0];
                        dm_addr  <= word_addr;
                        if (bad_access) begin
                            misaligned <= 1'b1;
                            done       <= 1'b1;
                            state      <= StDone;
                        end else begin
                            misaligned <= 1'b0;
                            if (!we) begin
                                state <= StLoad;
                            end else if (funct3 == 3'd2) begin
                                dm_din <= wdata;
                                dm_we  <= 1'b1;
                                state  <= StWrite;
                            end else begin
                                state <= StMerge;
                            end
                        end
                    end
                end
                StLoad: begin
                    rdata <= load_ext;
                    done  <= 1'b1;
                    state <= StDone;
                end
                StMerge: begin
                    dm_din <= merged;
                    dm_we  <= 1'b1;
                    state  <= StWrite;
                end
                StWrite: begin
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a word-wide memory behind the dm_* port.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    int checks = 0;
    int failures = 0;

    // Memory: async read, sync write; a bench-side port preloads words.
    logic [31:0] mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_idx = 8'd0;
    logic [31:0] tb_val = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[9:2]] <= dm_din;
        else if (tb_we) mem[tb_idx] <= tb_val;
    end
    assign dm_dout = mem[dm_addr[9:2]];

    dm_access_unit #(.WORD_IDX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .dm_addr    (dm_addr),
        .dm_we      (dm_we),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        tb_we  = 1'b1;
        tb_idx = idx;
        tb_val = val;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Called just after the acceptance edge; counts edges until done, plus write pulses.
    task automatic wait_done(output int lat, output int we_cnt, output logic [31:0] din);
        lat    = 0;
        we_cnt = 0;
        din    = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dm_we) begin
                we_cnt++;
                din = dm_din;
            end
            if (done) break;
            lat++;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    // Issue one request, return latency/write info; leaves the DUT back in IDLE.
    task automatic xfer(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int we_cnt,
                        output logic [31:0] din);
        @(negedge clk);
        req    = 1'b1;
        we     = w;
        funct3 = f3;
        addr   = a;
        wdata  = d;
        @(posedge clk);
        #1 req = 1'b0;
        wait_done(lat, we_cnt, din);
        @(posedge clk);
        #1;
    endtask

    int          lat;
    int          wec;
    logic [31:0] din;
    logic        we_seen;

    initial begin
        rst = 1'b1;
        req = 1'b0;
        we = 1'b0;
        funct3 = 3'd0;
        addr = 32'h0;
        wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_dmwe", {31'd0, dm_we}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_dmaddr", dm_addr, 32'h0);
        rst = 1'b0;

        poke(8'd4, 32'h8899AABB);
        poke(8'd8, 32'h5A5A5A5A);
        poke(8'd12, 32'h11223344);

        // lb with sign extension from the top lane
        xfer(1'b0, 3'd0, 32'h13, 32'h0, lat, wec, din);
        check("lb_data", rdata, 32'hFFFFFF88);
        check("lb_lat", lat, 32'd1);
        check("lb_mis", {31'd0, misaligned}, 32'd0);

        xfer(1'b0, 3'd5, 32'h12, 32'h0, lat, wec, din);
        check("lhu_data", rdata, 32'h00008899);
        xfer(1'b0, 3'd1, 32'h12, 32'h0, lat, wec, din);
        check("lh_data", rdata, 32'hFFFF8899);
        xfer(1'b0, 3'd4, 32'h10, 32'h0, lat, wec, din);
        check("lbu_data", rdata, 32'h000000BB);
        // Upper address bits are ignored: 0x410 aliases word 4
        xfer(1'b0, 3'd2, 32'h410, 32'h0, lat, wec, din);
        check("lw_data", rdata, 32'h8899AABB);
        check("lw_dmaddr", dm_addr, 32'h10);

        // sb read-modify-write
        xfer(1'b1, 3'd0, 32'h11, 32'h000000CC, lat, wec, din);
        check("sb_wepulses", wec, 32'd1);
        check("sb_din", din, 32'h8899CCBB);
        check("sb_lat", lat, 32'd2);
        check("sb_mem", mem[4], 32'h8899CCBB);
        check("sb_rdata_kept", rdata, 32'h8899AABB);

        // Error paths: no write, rdata untouched, zero latency
        xfer(1'b1, 3'd2, 32'h22, 32'hDEADBEEF, lat, wec, din);
        check("sw_mis", {31'd0, misaligned}, 32'd1);
        check("sw_mis_lat", lat, 32'd0);
        check("sw_mis_we", wec, 32'd0);
        check("sw_mis_mem", mem[8], 32'h5A5A5A5A);
        xfer(1'b0, 3'd1, 32'h05, 32'h0, lat, wec, din);
        check("lh_mis", {31'd0, misaligned}, 32'd1);
        check("lh_mis_rdata", rdata, 32'h8899AABB);
        xfer(1'b0, 3'd3, 32'h10, 32'h0, lat, wec, din);
        check("ld3_illegal", {31'd0, misaligned}, 32'd1);
        xfer(1'b1, 3'd4, 32'h10, 32'h0, lat, wec, din);
        check("st4_illegal", {31'd0, misaligned}, 32'd1);
        check("st4_mem", mem[4], 32'h8899CCBB);

        // sw writes directly in one cycle
        xfer(1'b1, 3'd2, 32'h20, 32'h01020304, lat, wec, din);
        check("sw_lat", lat, 32'd1);
        check("sw_din", din, 32'h01020304);
        check("sw_mem", mem[8], 32'h01020304);

        // sh high half
        xfer(1'b1, 3'd1, 32'h12, 32'h0000F00D, lat, wec, din);
        check("sh_mem", mem[4], 32'hF00DCCBB);

        // Reset asserted during MERGE of an sh
        @(negedge clk);
        req = 1'b1;
        we = 1'b1;
        funct3 = 3'd1;
        addr = 32'h32;
        wdata = 32'h0000BEEF;
        @(posedge clk);
        #2 rst = 1'b1;
        req = 1'b0;
        #1;
        check("rst_mid_dmwe", {31'd0, dm_we}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_dmaddr", dm_addr, 32'h0);
        check("rst_mid_dmdin", dm_din, 32'h0);
        check("rst_mid_rdata", rdata, 32'h0);
        we_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            we_seen |= dm_we;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            we_seen |= dm_we;
        end
        check("rst_mid_nowe", {31'd0, we_seen}, 32'd0);
        check("rst_mid_mem", mem[12], 32'h11223344);
        xfer(1'b0, 3'd2, 32'h30, 32'h0, lat, wec, din);
        check("post_rst_lw", rdata, 32'h11223344);

        // req held high through a sw: re-accepted only after IDLE
        @(negedge clk);
        req = 1'b1;
        we = 1'b1;
        funct3 = 3'd2;
        addr = 32'h40;
        wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        check("hold_write", {31'd0, dm_we}, 32'd1);
        @(negedge clk);
        check("hold_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("hold_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 req = 1'b0;
        wait_done(lat, wec, din);
        check("hold_second_we", wec, 32'd1);
        @(posedge clk);
        #1;
        xfer(1'b0, 3'd2, 32'h40, 32'h0, lat, wec, din);
        check("b2b_lw", rdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
